// File: rtl/nx_ram_1rw_ctrl.sv
// nx_ram_1rw_ctrl: write/read request arbiter and response buffer in front
// of a single-port 1rw RAM with one-cycle registered read data.
// Optional feature macro NX_RAM_1RW_CTRL_INIT_EN adds a post-reset zero
// sweep of the whole array; without it the controller resets into IDLE.
module nx_ram_1rw_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_bwe,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             init_done,
  output logic             oob_err,
  output logic             ram_cs,
  output logic             ram_we,
  output logic [AW-1:0]    ram_add,
  output logic [WIDTH-1:0] ram_din,
  output logic [WIDTH-1:0] ram_bwe,
  input  logic [WIDTH-1:0] ram_dout
);

  logic             in_init;
  logic             idle;
  logic [AW-1:0]    init_addr;
  logic             wr_oob;
  logic             rd_oob;
  logic             rd_elig;
  logic             wr_grant;
  logic             rd_grant;
  logic             last_rd_q;
  logic             rd_vld_p1;
  logic             rd_oob_p1;
  logic [WIDTH-1:0] fifo_mem [2];
  logic             wptr_q;
  logic             rptr_q;
  logic [1:0]       fifo_cnt_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;

`ifdef NX_RAM_1RW_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] init_cnt_q;

  // State register and sweep address counter; every reset restarts the sweep at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + AW'(1);
    end
  end

  // Leave INIT once the last word of the array has been written.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
  end

  assign in_init   = rst_n && (state_q == ST_INIT);
  assign idle      = rst_n && (state_q == ST_IDLE);
  assign init_done = (state_q == ST_IDLE);
  assign init_addr = init_cnt_q;
`else
  assign in_init   = 1'b0;
  assign idle      = rst_n;
  assign init_done = 1'b1;
  assign init_addr = '0;
`endif

  assign wr_oob = ({1'b0, wr_addr} >= (AW+1)'(DEPTH));
  assign rd_oob = ({1'b0, rd_addr} >= (AW+1)'(DEPTH));

  // Credit rule: a read may only start if its response has a guaranteed buffer slot.
  assign rd_elig  = (({1'b0, rd_vld_p1} + fifo_cnt_q) < 2'd2);
  assign wr_ready = idle && !(rd_valid && rd_elig && !last_rd_q);
  assign rd_ready = idle && rd_elig && !(wr_valid && last_rd_q);
  assign wr_grant = wr_valid && wr_ready;
  assign rd_grant = rd_valid && rd_ready;
  assign oob_err  = (wr_grant && wr_oob) || (rd_grant && rd_oob);

  // RAM port driven straight from the sweep or the granted request.
  always_comb begin
    ram_cs  = 1'b0;
    ram_we  = 1'b0;
    ram_add = '0;
    ram_din = '0;
    ram_bwe = '0;
    if (in_init) begin
      ram_cs  = 1'b1;
      ram_we  = 1'b1;
      ram_add = init_addr;
      ram_bwe = '1;
    end else if (wr_grant) begin
      ram_cs  = !wr_oob;
      ram_we  = 1'b1;
      ram_add = wr_addr;
      ram_din = wr_data;
      ram_bwe = wr_bwe;
    end else if (rd_grant) begin
      ram_cs  = !rd_oob;
      ram_add = rd_addr;
    end
  end

  // Stage p0 -> p1: remember a granted read until its RAM data arrives; track last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
      rd_oob_p1 <= 1'b0;
      last_rd_q <= 1'b1;
    end else begin
      rd_vld_p1 <= rd_grant;
      rd_oob_p1 <= rd_grant && rd_oob;
      if (wr_grant || rd_grant) last_rd_q <= rd_grant;
    end
  end

  assign push      = rd_vld_p1;
  assign push_data = rd_oob_p1 ? '0 : ram_dout;
  assign pop       = rsp_valid && rsp_ready;

  // Stage p1 -> response buffer: two-entry FIFO whose head is the response output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr_q] <= push_data;
        wptr_q           <= !wptr_q;
      end
      if (pop) rptr_q <= !rptr_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign rsp_valid = (fifo_cnt_q != 2'd0);
  assign rsp_data  = fifo_mem[rptr_q];

endmodule

// File: tb/tb_nx_ram_1rw_ctrl.sv
// Self-checking bench for nx_ram_1rw_ctrl (DEPTH=12 so out-of-range addresses exist).
// Covers both builds of the NX_RAM_1RW_CTRL_INIT_EN option.
module tb_nx_ram_1rw_ctrl;
  localparam int W  = 64;
  localparam int D  = 12;
  localparam int AW = 4;
  localparam int NA = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, ram_add;
  logic [W-1:0]  wr_data, wr_bwe, rsp_data, ram_din, ram_bwe, ram_dout;
  logic          rsp_valid, rsp_ready, init_done, oob_err, ram_cs, ram_we;
  logic          scramble;

  nx_ram_1rw_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bwe(wr_bwe),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done), .oob_err(oob_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_add(ram_add), .ram_din(ram_din), .ram_bwe(ram_bwe),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural 1rw RAM with registered read data; scramble fills it with garbage.
  logic [W-1:0] tb_ram [NA];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NA; i++) tb_ram[i] <= {$urandom, $urandom};
    end else if (ram_cs) begin
      if (ram_we) tb_ram[ram_add] <= (tb_ram[ram_add] & ~ram_bwe) | (ram_din & ram_bwe);
      else        ram_dout <= tb_ram[ram_add];
    end
  end

  // Reference model: array contents, ordered queue of expected responses, last-grant side.
  typedef struct { logic [W-1:0] data; int t; } rsp_t;
  rsp_t         exp_q[$];
  logic [W-1:0] ref_mem [NA];
  bit           m_last_rd;
  bit           m_w, m_r, g_w, g_r;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    bit exp_done;
`ifdef NX_RAM_1RW_CTRL_INIT_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif
    chk("rst_wr_ready", W'(wr_ready), '0);
    chk("rst_rd_ready", W'(rd_ready), '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_oob_err", W'(oob_err), '0);
    chk("rst_ram_cs", W'(ram_cs), '0);
    chk("rst_ram_we", W'(ram_we), '0);
    chk("rst_ram_add", W'(ram_add), '0);
    chk("rst_ram_din", ram_din, '0);
    chk("rst_ram_bwe", ram_bwe, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_init_done", W'(init_done), W'(exp_done));
  endtask

  // One clock cycle: drive at the falling edge, check against the model, advance.
  task automatic step(input bit wv, input int wa, input logic [W-1:0] wd, input logic [W-1:0] wb,
                      input bit rv, input int ra, input bit rr);
    bit elig, ewr, erd, ev, wo, ro;
    logic [W-1:0] rdat;
    wr_valid = wv; wr_addr = AW'(wa); wr_data = wd; wr_bwe = wb;
    rd_valid = rv; rd_addr = AW'(ra); rsp_ready = rr;
    #1;
    elig = (exp_q.size() < 2);
    ewr  = !(rv && elig && !m_last_rd);
    erd  = elig && !(wv && m_last_rd);
    ev   = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
    m_w  = wv && ewr;
    m_r  = rv && erd;
    wo   = (wa >= D);
    ro   = (ra >= D);
    g_w  = wr_valid && wr_ready;
    g_r  = rd_valid && rd_ready;
    chk("init_done", W'(init_done), W'(1));
    chk("wr_ready", W'(wr_ready), W'(ewr));
    chk("rd_ready", W'(rd_ready), W'(erd));
    chk("rsp_valid", W'(rsp_valid), W'(ev));
    if (ev) chk("rsp_data", rsp_data, exp_q[0].data);
    chk("oob_err", W'(oob_err), W'((m_w && wo) || (m_r && ro)));
    chk("ram_cs", W'(ram_cs), W'((m_w && !wo) || (m_r && !ro)));
    if (m_w) begin
      chk("ram_we_wr", W'(ram_we), W'(1));
      if (!wo) begin
        chk("ram_add_wr", W'(ram_add), W'(wa));
        chk("ram_din", ram_din, wd);
        chk("ram_bwe", ram_bwe, wb);
      end
    end else begin
      chk("ram_din_idle", ram_din, '0);
      chk("ram_bwe_idle", ram_bwe, '0);
      if (m_r) chk("ram_we_rd", W'(ram_we), '0);
      if (m_r && !ro) chk("ram_add_rd", W'(ram_add), W'(ra));
    end
    if (ev && rr) void'(exp_q.pop_front());
    if (m_w && !wo) ref_mem[wa] = (ref_mem[wa] & ~wb) | (wd & wb);
    if (m_r) begin
      rdat = ro ? '0 : ref_mem[ra];
      exp_q.push_back('{data: rdat, t: cyc + 2});
    end
    if (m_w || m_r) m_last_rd = m_r;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cyc(input bit rr);
    step(1'b0, 0, '0, '0, 1'b0, 0, rr);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle_cyc(1'b1);
  endtask

  task automatic do_wr(input int a, input logic [W-1:0] d, input logic [W-1:0] b);
    int n;
    n = 0;
    do begin
      step(1'b1, a, d, b, 1'b0, 0, 1'b1);
      n++;
    end while (!g_w && n < 20);
    chk("wr_accept", W'(g_w), W'(1));
  endtask

  task automatic do_rd(input int a);
    int n;
    n = 0;
    do begin
      step(1'b0, 0, '0, '0, 1'b1, a, 1'b1);
      n++;
    end while (!g_r && n < 20);
    chk("rd_accept", W'(g_r), W'(1));
  endtask

  task automatic contention(input string tag);
    logic [5:0] pat;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i, {$urandom, $urandom}, '1, 1'b1, i + 4, 1'b1);
      pat[i] = g_r;
    end
    chk(tag, W'(pat), W'(6'b101010));
  endtask

`ifdef NX_RAM_1RW_CTRL_INIT_EN
  task automatic init_cycle(input int i);
    wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("init_ram_cs", W'(ram_cs), W'(1));
    chk("init_ram_we", W'(ram_we), W'(1));
    chk("init_ram_add", W'(ram_add), W'(i));
    chk("init_ram_din", ram_din, '0);
    chk("init_ram_bwe", ram_bwe, '1);
    chk("init_done_low", W'(init_done), '0);
    chk("init_wr_ready", W'(wr_ready), '0);
    chk("init_rd_ready", W'(rd_ready), '0);
  endtask

  task automatic init_sweep();
    for (int i = 0; i < D; i++) begin
      init_cycle(i);
      @(posedge clk);
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    for (int i = 0; i < NA; i++) ref_mem[i] = '0;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, acc, n;
    rst_n = 1'b0; scramble = 1'b1;
    wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
    wr_addr = '0; rd_addr = '0; wr_data = '1; wr_bwe = '1;
    repeat (2) @(negedge clk);
    scramble = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_last_rd = 1'b1;
`ifdef NX_RAM_1RW_CTRL_INIT_EN
    for (int i = 0; i < 7; i++) begin
      init_cycle(i);
      @(posedge clk);
      @(negedge clk);
    end
    init_cycle(7);
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    init_sweep();
    for (int a = 0; a < D; a++) do_rd(a);
`else
    for (int a = 0; a < D; a++) do_wr(a, {$urandom, $urandom}, '1);
`endif
    drain(4);

    // Bit-enable merge and two-cycle read latency.
    do_wr(3, '1, '1);
    do_wr(3, '0, 64'h0000_0000_0000_00FF);
    do_rd(3);
    idle_cyc(1'b1);
    #1;
    chk("be_rsp_valid", W'(rsp_valid), W'(1));
    chk("be_rsp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FF00);
    drain(3);

    contention("contention_pattern");
    drain(4);

    // Back-pressure: only two reads fit while responses are held.
    idx = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 0, '0, '0, 1'b1, 1 + idx, 1'b0);
      if (g_r) begin idx++; acc++; end
    end
    chk("bp_accepts", W'(acc), W'(2));
    chk("bp_hold_data", rsp_data, ref_mem[1]);
    n = 0;
    while (idx < 3 && n < 20) begin
      step(1'b0, 0, '0, '0, 1'b1, 1 + idx, 1'b1);
      if (g_r) idx++;
      n++;
    end
    chk("bp_third_read", W'(idx), W'(3));
    drain(4);

    // Out-of-range write and read.
    do_wr(13, {$urandom, $urandom}, '1);
    do_rd(5);
    do_rd(14);
    do_rd(6);
    drain(4);

    for (int i = 0; i < 400; i++)
      step(1'($urandom), int'($urandom_range(0, NA - 1)), {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom), int'($urandom_range(0, NA - 1)), ($urandom_range(0, 3) != 0));
    drain(6);
    chk("queue_empty", W'(exp_q.size()), '0);

    // Reset with reads outstanding.
    step(1'b1, 2, {$urandom, $urandom}, '1, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 2, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset();
    exp_q.delete();
    m_last_rd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef NX_RAM_1RW_CTRL_INIT_EN
    init_sweep();
`endif
    contention("contention_after_reset");
    drain(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
